// File: rtl/sll_unit.sv
// ---------------------------------------------------------------------------
// sll_unit: registered logical-left shifter.
//
// C is A shifted left by the full-width unsigned amount B. Vacated LSBs are
// filled with zero. Any amount B >= WIDTH gives zero. The result is
// registered, so it appears one clock after the operands are accepted.
//
// Valid semantics: there is no ready. Every cycle with in_valid=1 is accepted.
// On the following cycle C holds that result and out_valid=1. In a cycle
// with in_valid=0, out_valid drops to 0 and C (and ovf) keep their last value.
// Operands are ignored entirely while in_valid=0.
//
// Optional feature, macro SLL_OVF_EN: adds the registered ovf output. ovf is
// set when any 1 bit of A is shifted out past the MSB.
//
// Parameters:
//   WIDTH     - width of A, B and C (2..64)
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous reset, active-high, priority over in_valid
//   in_valid  - A/B valid this cycle
//   A         - value to be shifted
//   B         - shift amount, full-width unsigned
//   C         - registered result A << B
//   out_valid - C holds a result captured from a valid input
//   ovf       - (SLL_OVF_EN only) a nonzero bit was shifted out
// ---------------------------------------------------------------------------
module sll_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             out_valid
`ifdef SLL_OVF_EN
    ,
    output logic             ovf
`endif
);

    // One extra bit so that WIDTH itself is representable for any WIDTH.
    localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH + 1)'(WIDTH);

    logic               in_range;
    logic [2*WIDTH-1:0] wide_shift;
    logic [WIDTH-1:0]   shift_result;

    // The shift is done at double width. When B is in range, the upper half
    // holds exactly the bits pushed past the MSB. The upper half is used by
    // the overflow detector.
    always_comb begin
        in_range     = ({1'b0, B} < SHIFT_LIMIT);
        wide_shift   = '0;
        shift_result = '0;
        if (in_range) begin
            wide_shift   = {{WIDTH{1'b0}}, A} << B;
            shift_result = wide_shift[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            C         <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            C         <= shift_result;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef SLL_OVF_EN
    logic bits_lost;

    // Out of range, every set bit of A is lost.
    always_comb begin
        bits_lost = 1'b0;
        if (in_range) begin
            bits_lost = |wide_shift[2*WIDTH-1:WIDTH];
        end else begin
            bits_lost = |A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= bits_lost;
        end
    end
`endif

endmodule

// File: tb/tb_sll_unit.sv
// ---------------------------------------------------------------------------
// tb_sll_unit: self-checking bench for sll_unit with WIDTH=4.
//
// Directed steps from the test plan, followed by random traffic. Each step
// drives one cycle of inputs and then compares the outputs with a reference
// model. The model computes A << B arithmetically as A * 2^B mod 2^WIDTH.
// ---------------------------------------------------------------------------
module tb_sll_unit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         out_valid;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    // scoreboard: results accepted but not yet observed
    logic [W-1:0] exp_q[$];

    // model state
    logic [W-1:0] m_c;
    logic         m_v;
    logic         m_ovf;

    sll_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .C         (c),
        .out_valid (out_valid)
`ifdef SLL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SLL_OVF_EN
    assign ovf = 1'b0;
`endif

    // ---------------- clock/reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_c(input int av, input int bv);
        if (bv >= W) return '0;
        return W'((av * (1 << bv)) % (1 << W));
    endfunction

    function automatic logic ref_ovf(input int av, input int bv);
        if (bv >= W) return (av != 0);
        return ((av * (1 << bv)) >= (1 << W));
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] q_c;
        chk("out_valid", 64'(out_valid), 64'(m_v));
        chk("c", 64'(c), 64'(m_c));
`ifdef SLL_OVF_EN
        chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
        if (m_v) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                q_c = exp_q.pop_front();
                chk("scoreboard_c", 64'(c), 64'(q_c));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle, advance the model, and check just after the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] av,
                        input logic [W-1:0] bv);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        if (r) begin
            m_c   = '0;
            m_v   = 1'b0;
            m_ovf = 1'b0;
            exp_q.delete();
        end else if (v) begin
            m_c   = ref_c(int'(av), int'(bv));
            m_ovf = ref_ovf(int'(av), int'(bv));
            m_v   = 1'b1;
            exp_q.push_back(m_c);
        end else begin
            m_v = 1'b0;
        end
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] inv;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rv;
        logic         rr;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        m_c = '0; m_v = 1'b0; m_ovf = 1'b0;

        // reset held with valid input pending
        step(1'b1, 1'b1, 4'hF, 4'h0);
        step(1'b1, 1'b1, 4'hF, 4'h0);
        // first valid input after release
        step(1'b0, 1'b1, 4'b0011, 4'b0001);
        chk("basic_0011_1", 64'(c), 64'(4'b0110));
        step(1'b0, 1'b1, 4'b0001, 4'b0011);
        chk("basic_0001_3", 64'(c), 64'(4'b1000));
        step(1'b0, 1'b1, 4'b1011, 4'b0000);
        chk("basic_b0", 64'(c), 64'(4'b1011));

        // over-range sweep
        for (int i = 0; i < 8; i++) begin
            inv = W'(i);
            step(1'b0, 1'b1, inv, ~inv);
            chk("overrange_zero", 64'(c), 64'd0);
        end

        // valid gating, with X operands while idle
        step(1'b0, 1'b1, 4'b0101, 4'd1);
        step(1'b0, 1'b0, 4'b1111, 4'd0);
        chk("gate_hold", 64'(c), 64'(4'b1010));
        step(1'b0, 1'b0, 'x, 'x);
        chk("gate_x_hold", 64'(c), 64'(4'b1010));

        // back-to-back, then reset with a fourth input in flight
        step(1'b0, 1'b1, 4'd1, 4'd1);
        step(1'b0, 1'b1, 4'd3, 4'd2);
        step(1'b0, 1'b1, 4'd7, 4'd0);
        step(1'b1, 1'b1, 4'd9, 4'd1);
        chk("midreset_c", 64'(c), 64'd0);
        step(1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 1'b1, 4'd2, 4'd1);

`ifdef SLL_OVF_EN
        step(1'b0, 1'b1, 4'b1100, 4'd1);
        chk("ovf_1100_1", 64'(ovf), 64'd1);
        step(1'b0, 1'b1, 4'b0011, 4'd2);
        chk("ovf_0011_2", 64'(ovf), 64'd0);
        step(1'b0, 1'b1, 4'b0001, 4'd9);
        chk("ovf_0001_9", 64'(ovf), 64'd1);
        step(1'b0, 1'b1, 4'b0000, 4'd15);
        chk("ovf_0_15", 64'(ovf), 64'd0);
        step(1'b0, 1'b0, 4'b1111, 4'd15);
        chk("ovf_hold", 64'(ovf), 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, W - 1))
                                             : W'($urandom_range(0, (1 << W) - 1));
            if (!rv && ($urandom_range(0, 1) == 0)) begin
                ra = 'x;
                rb = 'x;
            end
            step(rr, rv, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the run is stalled.
    initial begin
        #200000;
        $display("FAIL timeout: observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sll_unit.md
Name: sll_unit

Overview:
- Registered logical-left shifter for the datapath element catalog.
- Shifts operand A left by unsigned amount B and zero-fills from the LSB.
- Result appears one clock after the operands are accepted.
- A valid strobe travels with the data so downstream logic can qualify C.

Parameters:
- WIDTH, 4, bit width of A, B and C; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands A/B valid this cycle
- A  input  WIDTH  value to be shifted
- B  input  WIDTH  shift amount, full-width unsigned
- C  output  WIDTH  registered result A << B
- out_valid  output  1  C holds a result captured from a valid input
- ovf  output  1  present only with SLL_OVF_EN; a nonzero bit was shifted out

Behaviour:
- Single clock domain is clk. Reset is synchronous and active-high on rst, sampled only at a rising clk edge.
- Reset values: C = 0, out_valid = 0, ovf = 0. Reset has priority over a simultaneous in_valid.
- Latency is 1 cycle. At edge N with in_valid=1, C ← A << B and out_valid ← 1. Both are visible after edge N.
- At an edge with in_valid=0: out_valid ← 0 and C holds its previous value. C is not cleared.
- No back-pressure. Every cycle with in_valid=1 is accepted, giving one result per clock.
- Shift rules:
  - B is the full WIDTH-bit unsigned amount. It is not truncated to log2(WIDTH) bits.
  - 0 ≤ B < WIDTH: C = A shifted left B places, vacated LSBs = 0, bits past the MSB discarded.
  - B = 0: C = A.
  - B ≥ WIDTH: C = 0. Example WIDTH=4: B=8..15 gives 0.
  - A = 0 gives C = 0 for any B.
- The datapath is purely combinational into a single output register. No multi-cycle state and no FSM.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid = 0 on the next cycle. The first valid input after rst deasserts gives a result one cycle later.
- Unknown/X on A or B while in_valid=0 must not affect C or out_valid.

Optional Feature:
- Macro: SLL_OVF_EN.
- Defined:
  - Port ovf exists and is registered alongside C, with the same update, hold and reset rules as C.
  - ovf ← 1 when any 1 bit of A is lost: for B < WIDTH, any of the top B bits of A is nonzero; for B ≥ WIDTH, A ≠ 0.
  - Otherwise ovf ← 0.
- Not defined: port ovf and its register are absent. No other behaviour changes.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=4'hF, B=0 -> C=0, out_valid=0 (and ovf=0) throughout. Release rst -> first valid result appears 1 cycle later.
- Basic shifts, WIDTH=4, one cycle each:
  - A=0011, B=0001 -> C=0110
  - A=0001, B=0011 -> C=1000
  - A=1011, B=0000 -> C=1011
- Over-range sweep, in_valid=1, A=invect, B=~invect for invect=0..7 (B=15..8) -> C=0000 every cycle, out_valid=1 one cycle after each input.
- Valid gating: in_valid=1, A=0101, B=1 -> C=1010. Then in_valid=0 with A=1111, B=0 -> out_valid=0 and C stays 1010.
- Back-to-back then mid-stream reset: 3 consecutive valid inputs -> 3 consecutive valid results. Assert rst with a 4th input in flight -> out_valid=0, C=0.
- With SLL_OVF_EN:
  - A=1100, B=1 -> C=1000, ovf=1
  - A=0011, B=2 -> C=1100, ovf=0
  - A=0001, B=9 -> C=0, ovf=1
  - A=0, B=15 -> C=0, ovf=0
